// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the ram8-backed FIFO.
// Word width and depth are fixed by the ram8 storage array.
package ram_fifo_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned RAM_DEPTH = 8;
    localparam int unsigned PTR_W     = 3;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned CAPACITY  = 9;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/ram8.sv
// 8 x 16-bit RAM: synchronous write, combinational read.
// Ports:
//   clock   - write clock
//   in      - write data
//   address - read/write address
//   load    - write enable (write occurs on the rising edge)
//   out     - mem[address], combinational
// Contents are not reset.
module ram8
    import ram_fifo_pkg::*;
(
    input  logic             clock,
    input  word_t            in,
    input  logic [PTR_W-1:0] address,
    input  logic             load,
    output word_t            out
);

    word_t mem_q [RAM_DEPTH];

    always_ff @(posedge clock) begin
        if (load) begin
            mem_q[address] <= in;
        end
    end

    assign out = mem_q[address];

endmodule

// File: rtl/ram8_fifo.sv
// 9-word FIFO: 8 words in a ram8 instance plus a registered head-of-queue stage.
// Ports:
//   clock, reset         - single clock, synchronous active-high reset
//   in_data/in_valid/in_ready    - producer handshake
//   out_data/out_valid/out_ready - consumer handshake, out_data is registered
//   count                - words held (0..9)
// The single RAM port is shared between refilling the head and writing new
// words; refill wins, so in_ready drops in any cycle that refills.
module ram8_fifo
    import ram_fifo_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  word_t            in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output word_t            out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] RamFull = CNT_W'(RAM_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
    word_t            head_q, head_d;
    logic             head_vld_q, head_vld_d;

    logic push, pop, head_free, ram_empty, ram_full, refill, bypass;

    word_t            ram_in, ram_out;
    logic [PTR_W-1:0] ram_addr;
    logic             ram_load;

    // Handshake decode. out_ready -> in_ready is combinational through refill.
    always_comb begin
        ram_empty = (ram_cnt_q == '0);
        ram_full  = (ram_cnt_q == RamFull);
        head_free = !head_vld_q | out_ready;
        refill    = head_free & !ram_empty;
        in_ready  = !ram_full & !refill;
        push      = in_valid & in_ready;
        pop       = head_vld_q & out_ready;
        // Empty RAM and a free head: the word skips storage entirely.
        bypass    = push & head_free & ram_empty;
    end

    // RAM port mux; the write is gated in reset so a reset-cycle push is dropped.
    always_comb begin
        ram_load = push & !bypass & !reset;
        ram_addr = ram_load ? wr_ptr_q : rd_ptr_q;
        ram_in   = in_data;
    end

    ram8 u_ram8 (
        .clock   (clock),
        .in      (ram_in),
        .address (ram_addr),
        .load    (ram_load),
        .out     (ram_out)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        head_d     = head_q;
        head_vld_d = head_vld_q;

        if (refill) begin
            head_d     = ram_out;
            head_vld_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            ram_cnt_d  = ram_cnt_q - 1'b1;
        end else if (bypass) begin
            head_d     = in_data;
            head_vld_d = 1'b1;
        end else if (pop) begin
            head_vld_d = 1'b0;
        end

        // Never coincides with refill, so ram_cnt changes by at most one.
        if (ram_load) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    assign out_data  = head_q;
    assign out_valid = head_vld_q;
    assign count     = ram_cnt_q + CNT_W'(head_vld_q);

endmodule

// File: tb/tb_ram8_fifo.sv
// Bench for ram8_fifo: table of vectors with hand-derived expectations, plus
// hand-written sequences; out_data is checked against a scoreboard queue.
module tb_ram8_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;

    ram8_fifo dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          iv;
        logic [15:0] d;
        bit          ordy;
        bit          ir;
        bit          ov;
        logic [3:0]  cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          m_ram  = 0;
    bit          m_hv   = 1'b0;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    function automatic void add(bit iv, logic [15:0] d, bit ordy, bit ir, bit ov,
                                logic [3:0] cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.ir = ir; v.ov = ov; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // One cycle: drive, sample at the falling edge, update model, cross the edge.
    task automatic step(input bit iv, input logic [15:0] d, input bit ordy, input string tag,
                        input bit use_tbl, input bit t_ir, input bit t_ov,
                        input logic [3:0] t_cnt);
        bit hf, refill, m_ir, push, pop, bypass;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clock);
        hf     = !m_hv || ordy;
        refill = hf && (m_ram != 0);
        m_ir   = (m_ram != 8) && !refill;
        check({tag, " in_ready"}, 16'(in_ready), 16'(m_ir));
        check({tag, " out_valid"}, 16'(out_valid), 16'(m_hv));
        check({tag, " count"}, 16'(count), 16'(m_ram + int'(m_hv)));
        if (m_hv) begin
            if (sb.size() == 0) check({tag, " scoreboard empty"}, 16'(sb.size()), 16'd1);
            else check({tag, " out_data"}, out_data, sb[0]);
        end
        if (use_tbl) begin
            check({tag, " tbl in_ready"}, 16'(in_ready), 16'(t_ir));
            check({tag, " tbl out_valid"}, 16'(out_valid), 16'(t_ov));
            check({tag, " tbl count"}, 16'(count), 16'(t_cnt));
        end
        push   = iv && m_ir;
        pop    = m_hv && ordy;
        bypass = push && hf && (m_ram == 0);
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back(d);
        if (refill) begin
            m_hv = 1'b1;
            m_ram--;
        end else if (bypass) begin
            m_hv = 1'b1;
        end else if (pop) begin
            m_hv = 1'b0;
        end
        if (push && !bypass) m_ram++;
        @(posedge clock);
        #1;
    endtask

    task automatic s(input bit iv, input logic [15:0] d, input bit ordy, input string tag);
        step(iv, d, ordy, tag, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Inputs during reset are junk on purpose; they must be ignored.
    task automatic do_reset(input bit iv, input bit ordy);
        reset     = 1'b1;
        in_valid  = iv;
        in_data   = 16'hDEAD;
        out_ready = ordy;
        @(posedge clock);
        #1;
        check("rst out_valid", 16'(out_valid), 16'd0);
        check("rst count", 16'(count), 16'd0);
        check("rst out_data", out_data, 16'h0000);
        check("rst in_ready", 16'(in_ready), 16'd1);
        reset    = 1'b0;
        in_valid = 1'b0;
        m_ram    = 0;
        m_hv     = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t, want finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Expectations are values seen before the edge of that row's cycle.
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0);
        add(1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 9; k++) add(1'b1, 16'(k), 1'b0, 1'b1, k > 1, 4'(k - 1));
        add(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 4'd9);
        for (int k = 9; k >= 1; k--) add(1'b0, 16'h0000, 1'b1, k < 2, 1'b1, 4'(k));
        add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        do_reset(1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, $sformatf("vec%0d", i), 1'b1,
                 vecs[i].ir, vecs[i].ov, vecs[i].cnt);
        end

        // Pointer wrap: three rounds of 6 in / 6 out.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) s(1'b1, 16'h1000 + 16'(r * 6 + i), 1'b0, "wrap push");
            for (int i = 0; i < 6; i++) s(1'b0, 16'h0000, 1'b1, "wrap pop");
            check("wrap count", 16'(count), 16'd0);
        end

        // HEAD state streaming through bypass.
        s(1'b1, 16'h0100, 1'b0, "head load");
        for (int i = 1; i <= 8; i++) begin
            s(1'b1, 16'h0100 + 16'(i), 1'b1, "head stream");
            check("head stream count", 16'(count), 16'd1);
        end
        s(1'b0, 16'h0000, 1'b1, "head drain");
        s(1'b0, 16'h0000, 1'b0, "head idle");

        // BUFFERING with simultaneous push and pop: refill wins.
        for (int i = 0; i < 4; i++) s(1'b1, 16'h2000 + 16'(i), 1'b0, "buf fill");
        in_valid  = 1'b1;
        in_data   = 16'h2099;
        out_ready = 1'b1;
        #1;
        check("buf in_ready", 16'(in_ready), 16'd0);
        s(1'b1, 16'h2099, 1'b1, "buf both");
        check("buf count", 16'(count), 16'd3);
        check("buf head", out_data, 16'h2001);
        for (int i = 0; i < 3; i++) s(1'b0, 16'h0000, 1'b1, "buf drain");
        s(1'b0, 16'h0000, 1'b0, "buf idle");

        // Reset at count 5 discards everything.
        for (int i = 0; i < 5; i++) s(1'b1, 16'h3000 + 16'(i), 1'b0, "pre-rst fill");
        check("pre-rst count", 16'(count), 16'd5);
        do_reset(1'b1, 1'b1);
        s(1'b1, 16'hBEEF, 1'b0, "post-rst push");
        check("post-rst data", out_data, 16'hBEEF);
        check("post-rst count", 16'(count), 16'd1);
        s(1'b0, 16'h0000, 1'b1, "post-rst pop");
        s(1'b0, 16'h0000, 1'b0, "post-rst idle");
        s(1'b0, 16'h0000, 1'b1, "post-rst empty pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
